alu_operand_sequencer: RTL
==========================

Name: alu_operand_sequencer

Overview:
- Front-end and result stage for the Mini ALU.
- Accepts two operands serially over one shared WIDTH-bit bus using a valid/ready handshake, and latches the opcode with the second operand.
- Holds both operands stable on op_a/op_b for the ALU datapath (comparator, adder and the other units), waits a programmable settle time, then registers alu_result and offers it downstream with a valid/ready handshake.

Parameters:
- WIDTH, 6, operand and result width.
- OP_W, 3, opcode width.
- EXEC_CYCLES, 1, cycles spent in EXEC before alu_result is captured; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  operand bus.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  sequencer can accept data_in this cycle.
- op_sel  input  OP_W  opcode; sampled only when operand B is accepted.
- op_a  output  WIDTH  registered operand A to the ALU.
- op_b  output  WIDTH  registered operand B to the ALU.
- op_code  output  OP_W  registered opcode to the ALU mux.
- alu_result  input  WIDTH  combinational ALU output, a function of op_a/op_b/op_code.
- result  output  WIDTH  registered ALU result.
- result_valid  output  1  result is valid.
- result_ready  input  1  downstream accepts result.
- busy  output  1  high in every state except LOAD_A.

Behaviour:
- Reset, applied on any clock edge with reset=1, in any state including mid-transaction:
  - state=LOAD_A; op_a, op_b, op_code, result and the exec counter all 0.
  - result_valid=0.
  - Any partially loaded transaction is discarded.
- Transfer rule: a transfer occurs on a rising edge where valid && ready. No transfer occurs while reset=1.
- State machine, four states:
  - LOAD_A: data_ready=1. On data_valid: op_a<=data_in, go to LOAD_B.
  - LOAD_B: data_ready=1. On data_valid: op_b<=data_in, op_code<=op_sel, counter<=EXEC_CYCLES-1, go to EXEC. Without data_valid, stay in LOAD_B; op_a is retained indefinitely.
  - EXEC: data_ready=0.
    - Counter>0: decrement.
    - Counter=0: result<=alu_result, result_valid<=1, go to DONE.
  - DONE: data_ready=0, result_valid=1, result stable.
    - On result_ready: result_valid<=0, go to LOAD_A.
    - Without result_ready: hold state, result and operands indefinitely.
- Output properties:
  - data_ready is a combinational decode of state only, never of data_valid.
  - op_a changes only on an A transfer; op_b and op_code change only on a B transfer.
  - Operands therefore stay stable from the B transfer until the next A transfer.
- Latency: with B accepted at edge N, result is captured and result_valid rises at edge N+EXEC_CYCLES. With EXEC_CYCLES=1, result_valid is high one cycle after the B transfer.
- Back-to-back throughput: the minimum transaction is 2 load cycles + EXEC_CYCLES + 1 DONE cycle. Operand A of the next transaction can transfer on the cycle after the result handshake, not on the same cycle.
- Simultaneous events:
  - result_ready asserted before DONE has no effect.
  - data_valid held high outside LOAD_A/LOAD_B is ignored, and its data is not consumed.
- Widths:
  - All datapath registers are exactly WIDTH bits; no extension or truncation.
  - The counter is 4 bits.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding (LOAD_A=2'd0, LOAD_B=2'd1, EXEC=2'd2, DONE=2'd3);
  - default WIDTH=6 and OP_W=3;
  - ALU opcode constants, including OP_LT for the bitwise less-than unit.
- No sub-module: the FSM, the counter and the registers are implemented in one module.

Test Plan:
- Reset: assert reset for 2 cycles, then release → op_a=op_b=result=0, result_valid=0, data_ready=1, busy=0.
- Basic LT transaction, EXEC_CYCLES=1, with a bitwise less-than model driving alu_result:
  - stimulus: A=6'b101010, B=6'b010110, op_sel=OP_LT;
  - response: op_b and op_code update at the B edge; result=6'b010100 with result_valid=1 exactly one edge later; result_ready=1 → result_valid=0 on the next edge and data_ready=1.
- Gaps and stalls, A=6'd63, B=6'd0:
  - data_valid low for 5 cycles between A and B → op_a stays 63 throughout;
  - result_ready held low for 10 cycles → result_valid, result, op_a and op_b all stay constant;
  - result = 6'b000000.
- Protocol robustness: data_valid held high through EXEC and DONE with data_in=6'h15 → no transfer occurs; op_a/op_b are unchanged; the next A captured is the value present on the cycle after the result handshake.
- Reset mid-operation: assert reset in LOAD_B, in EXEC and in DONE (separately) → next state is LOAD_A, result_valid=0, all registers 0; a following clean transaction A=5, B=9 completes correctly.
- EXEC_CYCLES=4: B accepted at edge N → result_valid rises at edge N+4; changing alu_result at edges N+1..N+3 has no effect, and the value present before edge N+4 is the one captured.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the Mini ALU: sequencer state encoding, default widths
// and the opcode map used by the ALU result mux.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 6;
  localparam int unsigned DEFAULT_OP_W  = 3;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam logic [DEFAULT_OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [DEFAULT_OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [DEFAULT_OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [DEFAULT_OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [DEFAULT_OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [DEFAULT_OP_W-1:0] OP_LT   = 3'd5;  // bitwise a[i] < b[i]
  localparam logic [DEFAULT_OP_W-1:0] OP_EQ   = 3'd6;
  localparam logic [DEFAULT_OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_operand_sequencer.sv
// Serial operand loader and result stage for the Mini ALU: collects A then B
// (with opcode), holds them for the datapath, waits EXEC_CYCLES, registers the result.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned OP_W        = DEFAULT_OP_W,
  parameter int unsigned EXEC_CYCLES = 1               // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [OP_W-1:0]  op_sel,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OP_W-1:0]  op_code,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]  op_code_q, op_code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ready is a pure state decode so it never depends on data_valid.
  assign data_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign busy         = (state_q != LOAD_A);
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_code      = op_code_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

  always_comb begin
    // NOTE: every signal gets a hold default first so no branch can leave one
    // unassigned and infer a latch.
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_code_d      = op_code_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    cnt_d          = cnt_q;

    unique case (state_q)
      LOAD_A: begin
        if (data_valid) begin
          op_a_d  = data_in;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (data_valid) begin
          op_b_d    = data_in;
          op_code_d = op_sel;
          cnt_d     = EXEC_LOAD;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d       = alu_result;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LOAD_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_code_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_code_q      <= op_code_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      cnt_q          <= cnt_d;
    end
  end

endmodule
